// File: rtl/load_ab_dbuf.sv
// load_ab_dbuf: double-buffered A/B operand loader for one PE.
//   A words arrive on a valid/ready stream; this PE keeps the A_PART words of
//   each tile whose slot (count_a upper bits) matches PID, in one of two banks.
//   Each B word is paired in turn with every stored A word of the current bank.
//   After B_NUM B words the bank is released and reading moves to the other bank.
// Ports:
//   clk, rst (sync, active-low)
//   a_data_in/a_valid_in/a_ready_out : A stream
//   b_data_in/b_valid_in/b_ready_out : B stream
//   data_a_out/data_b_out/valid_ab_out : operand pair, RD_DELAY after issue
//   tile_done_out : pulse with the last pair of a tile
module load_ab_dbuf #(
  parameter int D_WIDTH      = 64,
  parameter int A_NUM_WIDTH  = 3,
  parameter int A_PART_WIDTH = 1,
  parameter int B_NUM_WIDTH  = 2,
  parameter int PID          = 0,
  parameter int RD_DELAY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] a_data_in,
  input  logic               a_valid_in,
  output logic               a_ready_out,
  input  logic [D_WIDTH-1:0] b_data_in,
  input  logic               b_valid_in,
  output logic               b_ready_out,
  output logic [D_WIDTH-1:0] data_a_out,
  output logic [D_WIDTH-1:0] data_b_out,
  output logic               valid_ab_out,
  output logic               tile_done_out
);

  localparam int A_PART = 1 << A_PART_WIDTH;
  localparam int DEPTH  = 2 * A_PART;
  localparam logic [A_NUM_WIDTH-1:0] PID_V = A_NUM_WIDTH'(PID);

  typedef enum logic {IDLE, RUN} state_t;

  // A buffer, addressed {bank, index}; contents are not reset
  logic [D_WIDTH-1:0] abuf_q [DEPTH];

  logic [1:0]             full_q, full_d;
  logic                   load_bank_q, load_bank_d;
  logic                   read_bank_q, read_bank_d;
  logic [A_NUM_WIDTH-1:0] count_a_q, count_a_d;
  state_t                 state_q, state_d;
  logic [A_PART_WIDTH-1:0] idx_q, idx_d;
  logic [B_NUM_WIDTH-1:0] count_b_q, count_b_d;
  logic [D_WIDTH-1:0]     b_lat_q, b_lat_d;

  // read pipeline: stage 1 holds the synchronous buffer read, stage 2 the extra delay
  logic               v1_q, v1_d, t1_q, t1_d, v2_q, t2_q;
  logic [D_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, a2_q, b2_q;

  logic                    a_hs, a_wr, a_last;
  logic [A_PART_WIDTH:0]   a_waddr, issue_addr;
  logic                    issue, tile_last, clr_full;

  assign a_ready_out = !full_q[load_bank_q];

  always_comb begin
    a_hs        = a_valid_in && a_ready_out;
    a_wr        = a_hs && ((count_a_q >> A_PART_WIDTH) == PID_V);
    a_waddr     = {load_bank_q, count_a_q[A_PART_WIDTH-1:0]};
    a_last      = a_hs && (count_a_q == '1);
    count_a_d   = a_hs ? count_a_q + A_NUM_WIDTH'(1) : count_a_q;
    load_bank_d = load_bank_q ^ a_last;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_b_d   = count_b_q;
    b_lat_d     = b_lat_q;
    read_bank_d = read_bank_q;
    b_ready_out = 1'b0;
    issue       = 1'b0;
    tile_last   = 1'b0;
    clr_full    = 1'b0;
    issue_addr  = {read_bank_q, idx_q};
    case (state_q)
      IDLE: begin
        if (full_q[read_bank_q] && b_valid_in) begin
          b_ready_out = 1'b1;
          b_lat_d     = b_data_in;
          idx_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (idx_q == '1) begin
          idx_d = '0;
          if (count_b_q != '1) begin
            count_b_d = count_b_q + B_NUM_WIDTH'(1);
            if (b_valid_in) begin
              b_ready_out = 1'b1;
              b_lat_d     = b_data_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            // last pair of the tile: release bank, chain into the other bank if ready
            tile_last   = 1'b1;
            clr_full    = 1'b1;
            read_bank_d = !read_bank_q;
            count_b_d   = '0;
            if (full_q[!read_bank_q] && b_valid_in) begin
              b_ready_out = 1'b1;
              b_lat_d     = b_data_in;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          idx_d = idx_q + A_PART_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // set and clear always target different banks, so both apply together
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[read_bank_q] = 1'b0;
    if (a_last)   full_d[load_bank_q] = 1'b1;
  end

  always_comb begin
    v1_d = issue;
    t1_d = tile_last;
    b1_d = b_lat_q;
    a1_d = abuf_q[issue_addr];
  end

  always_ff @(posedge clk) begin
    if (a_wr) abuf_q[a_waddr] <= a_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q      <= '0;
      load_bank_q <= 1'b0;
      read_bank_q <= 1'b0;
      count_a_q   <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      count_b_q   <= '0;
      b_lat_q     <= '0;
      v1_q        <= 1'b0;
      t1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      v2_q        <= 1'b0;
      t2_q        <= 1'b0;
      a2_q        <= '0;
      b2_q        <= '0;
    end else begin
      full_q      <= full_d;
      load_bank_q <= load_bank_d;
      read_bank_q <= read_bank_d;
      count_a_q   <= count_a_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_b_q   <= count_b_d;
      b_lat_q     <= b_lat_d;
      v1_q        <= v1_d;
      t1_q        <= t1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      v2_q        <= v1_q;
      t2_q        <= t1_q;
      a2_q        <= a1_q;
      b2_q        <= b1_q;
    end
  end

  assign valid_ab_out  = (RD_DELAY == 1) ? v1_q : v2_q;
  assign tile_done_out = (RD_DELAY == 1) ? t1_q : t2_q;
  assign data_a_out    = (RD_DELAY == 1) ? a1_q : a2_q;
  assign data_b_out    = (RD_DELAY == 1) ? b1_q : b2_q;

endmodule

// File: tb/tb_load_ab_dbuf.sv
// Testbench for load_ab_dbuf (D_WIDTH=16, A_NUM_WIDTH=3, A_PART_WIDTH=1,
// B_NUM_WIDTH=2, PID=1, RD_DELAY=2).
module tb_load_ab_dbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a_data_in = '0;
  logic        a_valid_in = 1'b0;
  logic        a_ready_out;
  logic [15:0] b_data_in = '0;
  logic        b_valid_in = 1'b0;
  logic        b_ready_out;
  logic [15:0] data_a_out, data_b_out;
  logic        valid_ab_out, tile_done_out;

  load_ab_dbuf #(
    .D_WIDTH(16), .A_NUM_WIDTH(3), .A_PART_WIDTH(1),
    .B_NUM_WIDTH(2), .PID(1), .RD_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .a_data_in(a_data_in), .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
    .b_data_in(b_data_in), .b_valid_in(b_valid_in), .b_ready_out(b_ready_out),
    .data_a_out(data_a_out), .data_b_out(data_b_out),
    .valid_ab_out(valid_ab_out), .tile_done_out(tile_done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        d;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        d;
    int          cyc;
  } obs_t;

  vec_t tab[8];
  obs_t q[$];
  int   cyc = 0;
  int   done_cnt = 0, stray = 0;
  int   a_hs_count = 0, b_hs_count = 0, b_at17 = -1;
  int   pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_ab_out) q.push_back('{data_a_out, data_b_out, tile_done_out, cyc});
    if (tile_done_out) done_cnt++;
    if (tile_done_out && !valid_ab_out) stray++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    done_cnt = 0; stray = 0; a_hs_count = 0; b_hs_count = 0; b_at17 = -1;
  endtask

  task automatic send_a(input logic [15:0] v);
    int g = 0;
    @(negedge clk);
    a_data_in = v; a_valid_in = 1'b1;
    #1;
    while (!a_ready_out && g < 300) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 300) chk("a_timeout", 32'(a_ready_out), 32'd1);
    else begin
      @(posedge clk);
      a_hs_count++;
      if (a_hs_count == 17) b_at17 = b_hs_count;
    end
  endtask

  task automatic send_b(input logic [15:0] v);
    int g = 0;
    @(negedge clk);
    b_data_in = v; b_valid_in = 1'b1;
    #1;
    while (!b_ready_out && g < 300) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 300) chk("b_timeout", 32'(b_ready_out), 32'd1);
    else begin
      @(posedge clk);
      b_hs_count++;
    end
  endtask

  task automatic a_idle(); @(negedge clk); a_valid_in = 1'b0; endtask
  task automatic b_idle(); @(negedge clk); b_valid_in = 1'b0; endtask

  task automatic wait_pairs(input int n);
    int k = 0;
    while (q.size() < n && k < 400) begin
      @(negedge clk); #2; k++;
    end
    repeat (6) @(negedge clk);
    #2;
    chk("pair_count", 32'(q.size()), 32'(n));
  endtask

  task automatic compare_tile(input int start, input logic [15:0] abase, input logic [15:0] bbase);
    obs_t o;
    for (int k = 0; k < 8; k++) begin
      if (start + k < q.size()) o = q[start + k];
      else o = '{16'hxxxx, 16'hxxxx, 1'bx, 0};
      chk($sformatf("pair%0d_a", start + k), 32'(o.a), 32'(tab[k].a - 16'h10 + abase));
      chk($sformatf("pair%0d_b", start + k), 32'(o.b), 32'(tab[k].b - 16'hB0 + bbase));
      chk($sformatf("pair%0d_done", start + k), 32'(o.d), 32'(tab[k].d));
    end
  endtask

  task automatic basic_tile();
    for (int k = 0; k < 8; k++) send_a(16'h10 + 16'(k));
    a_idle();
    for (int j = 0; j < 4; j++) send_b(tab[2*j].b_in);
    b_idle();
    wait_pairs(8);
    compare_tile(0, 16'h10, 16'hB0);
    if (q.size() >= 8) chk("t1_consecutive", 32'(q[7].cyc - q[0].cyc), 32'd7);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_stray_done", 32'(stray), 32'd0);
  endtask

  function automatic logic [15:0] a_word(input int k);
    if (k < 8) return 16'h10 + 16'(k);
    else if (k < 16) return 16'h20 + 16'(k - 8);
    else return 16'h40 + 16'(k - 16);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // PID=1 keeps words 2 and 3 of each 8-word A tile
    tab[0] = '{16'hB0, 16'h12, 16'hB0, 1'b0};
    tab[1] = '{16'hB0, 16'h13, 16'hB0, 1'b0};
    tab[2] = '{16'hB1, 16'h12, 16'hB1, 1'b0};
    tab[3] = '{16'hB1, 16'h13, 16'hB1, 1'b0};
    tab[4] = '{16'hB2, 16'h12, 16'hB2, 1'b0};
    tab[5] = '{16'hB2, 16'h13, 16'hB2, 1'b0};
    tab[6] = '{16'hB3, 16'h12, 16'hB3, 1'b0};
    tab[7] = '{16'hB3, 16'h13, 16'hB3, 1'b1};

    // reset held two cycles
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_ab_out), 32'd0);
    chk("rst_done", 32'(tile_done_out), 32'd0);
    chk("rst_data_a", 32'(data_a_out), 32'd0);
    chk("rst_data_b", 32'(data_b_out), 32'd0);
    chk("rst_b_ready", 32'(b_ready_out), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_a_ready", 32'(a_ready_out), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready_out), 32'd0);

    // single tile, continuous B
    basic_tile();

    // three A tiles with no B: loader stalls after two, then 12 B words drain all
    reset_dut();
    fork
      begin
        for (int k = 0; k < 24; k++) send_a(a_word(k));
        a_idle();
      end
      begin
        int g = 0;
        while (a_hs_count < 16 && g < 300) begin @(negedge clk); g++; end
        repeat (5) @(negedge clk);
        #1;
        chk("a_ready_held", 32'(a_ready_out), 32'd0);
        chk("a_hs_held", 32'(a_hs_count), 32'd16);
        for (int j = 0; j < 8; j++) send_b(16'hC0 + 16'(j));
        for (int j = 0; j < 4; j++) send_b(16'hD0 + 16'(j));
        b_idle();
      end
    join
    wait_pairs(24);
    compare_tile(0, 16'h10, 16'hC0);
    compare_tile(8, 16'h20, 16'hC4);
    compare_tile(16, 16'h40, 16'hD0);
    if (q.size() >= 16) chk("two_tile_consecutive", 32'(q[15].cyc - q[0].cyc), 32'd15);
    chk("three_tile_done_cnt", 32'(done_cnt), 32'd3);
    chk("three_tile_stray", 32'(stray), 32'd0);
    chk("a17_after_drain", 32'(b_at17 >= 4), 32'd1);

    // B with idle gaps
    reset_dut();
    for (int k = 0; k < 8; k++) send_a(16'h10 + 16'(k));
    a_idle();
    for (int j = 0; j < 4; j++) begin
      send_b(tab[2*j].b_in);
      b_idle();
      repeat (2) @(negedge clk);
    end
    wait_pairs(8);
    compare_tile(0, 16'h10, 16'hB0);
    if (q.size() >= 8) chk("gaps_present", 32'((q[7].cyc - q[0].cyc) > 7), 32'd1);
    chk("gap_done_cnt", 32'(done_cnt), 32'd1);

    // reset during RUN, then repeat the single tile
    reset_dut();
    for (int k = 0; k < 8; k++) send_a(16'h10 + 16'(k));
    a_idle();
    @(negedge clk);
    b_data_in = 16'hB0; b_valid_in = 1'b1;
    begin
      int g = 0;
      while (q.size() < 2 && g < 100) begin @(negedge clk); #2; g++; end
    end
    @(negedge clk);
    rst = 1'b0; b_valid_in = 1'b0;
    @(negedge clk); #1;
    chk("midrst_valid", 32'(valid_ab_out), 32'd0);
    chk("midrst_done", 32'(tile_done_out), 32'd0);
    chk("midrst_data_a", 32'(data_a_out), 32'd0);
    chk("midrst_data_b", 32'(data_b_out), 32'd0);
    chk("midrst_b_ready", 32'(b_ready_out), 32'd0);
    chk("midrst_a_ready", 32'(a_ready_out), 32'd1);
    rst = 1'b1;
    q.delete();
    done_cnt = 0; stray = 0; a_hs_count = 0; b_hs_count = 0;
    basic_tile();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/load_ab_dbuf.md
LOAD_AB_DBUF -- requirements
Module: load_ab_dbuf

Interface
REQ-001 SHALL have parameter D_WIDTH, 64: A/B word width in bits.
REQ-002 SHALL have parameter A_NUM_WIDTH, 3: log2 of A words per tile across all PEs.
REQ-003 SHALL have parameter A_PART_WIDTH, 1: log2 of A words per tile kept by this PE (A_PART = 2^A_PART_WIDTH); A_PART_WIDTH <= A_NUM_WIDTH.
REQ-004 SHALL have parameter B_NUM_WIDTH, 2: log2 of B words per tile (B_NUM = 2^B_NUM_WIDTH).
REQ-005 SHALL have parameter PID, 0: PE index, 0 <= PID < 2^(A_NUM_WIDTH-A_PART_WIDTH).
REQ-006 SHALL have parameter RD_DELAY, 2: A-buffer read latency in cycles, legal values 1 or 2.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 a_data_in  in  D_WIDTH  A stream word.
REQ-010 a_valid_in  in  1  A word present.
REQ-011 a_ready_out  out  1  A word consumed when a_valid_in && a_ready_out.
REQ-012 b_data_in  in  D_WIDTH  B stream word.
REQ-013 b_valid_in  in  1  B word present.
REQ-014 b_ready_out  out  1  B word consumed when b_valid_in && b_ready_out.
REQ-015 data_a_out  out  D_WIDTH  A operand.
REQ-016 data_b_out  out  D_WIDTH  B operand paired with data_a_out.
REQ-017 valid_ab_out  out  1  operand pair valid this cycle.
REQ-018 tile_done_out  out  1  one-cycle pulse when a tile's last pair is issued.

Function
REQ-019 SHALL hold a two-bank A buffer, depth 2*A_PART, address {bank, index}; per-bank full flag; independent load_bank and read_bank pointers.
REQ-020 a_ready_out SHALL equal !full[load_bank], combinational.
REQ-021 count_a (A_NUM_WIDTH bits) SHALL increment on every A handshake, wrapping to 0 after all-ones.
REQ-022 A handshake with count_a[A_NUM_WIDTH-1:A_PART_WIDTH] == PID SHALL write a_data_in to {load_bank, count_a[A_PART_WIDTH-1:0]}; other words consumed and discarded.
REQ-023 A handshake with count_a all-ones SHALL set full[load_bank] and toggle load_bank next cycle.
REQ-024 Read FSM states IDLE, RUN; idx (A_PART_WIDTH bits) and count_b (B_NUM_WIDTH bits).
REQ-025 IDLE: if full[read_bank] && b_valid_in, assert b_ready_out, latch B word, idx=0, go RUN; else stay.
REQ-026 RUN: each cycle issue read of {read_bank, idx} paired with latched B; idx increments, wrapping at A_PART-1.
REQ-027 At idx == A_PART-1 with count_b != all-ones: count_b++; if b_valid_in, assert b_ready_out, latch next B, stay RUN (no bubble); else go IDLE.
REQ-028 At idx == A_PART-1 with count_b all-ones: clear full[read_bank], toggle read_bank, count_b=0, pulse tile_done_out; accept next B same cycle only if other bank full and b_valid_in, else IDLE.
REQ-029 b_ready_out SHALL be asserted only in accept cycles of REQ-025/027/028.
REQ-030 valid_ab_out, data_b_out, data_a_out SHALL appear exactly RD_DELAY cycles after issue; tile_done_out aligned with the last valid_ab_out of the tile.
REQ-031 Set of full[load_bank] and clear of full[read_bank] in one cycle SHALL both take effect.
REQ-032 Steady state SHALL sustain one pair per cycle, A_PART*B_NUM pairs per tile.
REQ-033 Bank order: banks filled and drained alternately starting at bank 0; no write to a full bank.

Reset
REQ-034 rst low at a clock edge SHALL clear full flags, pointers, count_a, count_b, idx, FSM to IDLE, delay pipeline; all outputs 0 next cycle; a_ready_out=1 after reset.
REQ-035 Reset mid-tile SHALL discard partial tiles; buffer contents need not be cleared.

Verification (D_WIDTH=16, A_NUM_WIDTH=3, A_PART_WIDTH=1, B_NUM_WIDTH=2, PID=1, RD_DELAY=2)
REQ-036 Hold rst=0 two cycles -> all outputs 0; after release a_ready_out=1, b_ready_out=0.
REQ-037 A words 0x10..0x17, then B 0xB0..0xB3 continuously valid -> 8 consecutive valid_ab_out: (0x12,0xB0),(0x13,0xB0),(0x12,0xB1)...(0x13,0xB3); tile_done_out with last.
REQ-038 24 A words, no B -> a_ready_out low after 16th handshake; 17th word held until first tile drains.
REQ-039 Two tiles preloaded (tile 2 = 0x20..0x27), 8 B words continuous -> 16 consecutive valid cycles, second half uses 0x22/0x23, two tile_done_out pulses.
REQ-040 b_valid_in low 3 cycles between B words -> valid_ab_out gaps, no duplicated or lost pairs.
REQ-041 rst low during RUN -> outputs 0 next cycle; repeat REQ-037 stimulus reproduces identical output.
